// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction-memory write port.
//
// Accepts a framed byte stream and turns it into full-word imem writes.
//   Frame: SYNC | ADDR[4] (byte address, LE) | LEN[2] (word count N, LE)
//          | DATA[4N] (LE words) | CHK[1] (XOR of all DATA bytes)
// The core is held (core_run_o low) until a frame completes with a good
// checksum.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   byte_i        stream byte
//   byte_valid_i  byte_i valid
//   byte_ready_o  always 1 (the loader never back-pressures)
//   mem_addr_o    imem word address of the write
//   mem_wdata_o   imem write data
//   mem_wen_o     imem byte write enables (all lanes together, 1-cycle pulse)
//   core_run_o    fetch-stage PC increment enable
//   busy_o        frame in progress (ADDR, LEN, DATA, CHK)
//   done_o        last frame loaded with a good checksum
//   err_o         last frame rejected (header or checksum)
module imem_loader #(
  parameter int         ADDR_WIDTH = 10,
  parameter int         DATA_WIDTH = 32,
  parameter int         DATA_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [DATA_BYTES-1:0] mem_wen_o,
  output logic                  core_run_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // Header range arithmetic is wide enough that start_word + N never wraps.
  localparam int SUM_W = ADDR_WIDTH + 17;
  localparam int BC_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [SUM_W-1:0] DEPTH   = SUM_W'(1) << ADDR_WIDTH;
  localparam logic [BC_W-1:0]  LAST_BC = BC_W'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t state, state_nxt;

  logic                  acc;
  logic [31:0]           addr_buf;
  logic [7:0]            len_lo;
  logic [15:0]           len_full;
  logic [1:0]            hdr_cnt;
  logic [BC_W-1:0]       byte_cnt;
  logic [DATA_WIDTH-9:0] data_buf;
  logic [7:0]            chk_xor;
  logic [15:0]           words_left;
  logic [ADDR_WIDTH-1:0] word_ptr;
  logic [ADDR_WIDTH-1:0] start_word;
  logic                  hdr_bad;

  // Reject misaligned addresses, addresses beyond the imem, and frames that
  // would run past the last word.
  function automatic logic header_bad(input logic [31:0] addr,
                                      input logic [15:0] n);
    logic [SUM_W-1:0] end_word;
    end_word = SUM_W'(addr[ADDR_WIDTH+1:2]) + SUM_W'(n);
    return (addr[1:0] != 2'b00) ||
           ((addr >> (ADDR_WIDTH + 2)) != 32'd0) ||
           (end_word > DEPTH);
  endfunction

  assign byte_ready_o = 1'b1;
  assign acc          = byte_valid_i & byte_ready_o;
  assign len_full     = {byte_i, len_lo};
  assign start_word   = addr_buf[ADDR_WIDTH+1:2];
  assign hdr_bad      = header_bad(addr_buf, len_full);
  assign busy_o       = (state == S_ADDR) || (state == S_LEN) ||
                        (state == S_DATA) || (state == S_CHK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc) begin
      case (state)
        S_IDLE, S_DONE, S_ERR:
          if (byte_i == SYNC_BYTE) state_nxt = S_ADDR;
        S_ADDR:
          if (hdr_cnt == 2'd3) state_nxt = S_LEN;
        S_LEN:
          if (hdr_cnt == 2'd1) begin
            if (hdr_bad)               state_nxt = S_ERR;
            else if (len_full == 16'd0) state_nxt = S_CHK;
            else                        state_nxt = S_DATA;
          end
        S_DATA:
          if ((byte_cnt == LAST_BC) && (words_left == 16'd1)) state_nxt = S_CHK;
        S_CHK:
          state_nxt = (byte_i == chk_xor) ? S_DONE : S_ERR;
        default:
          state_nxt = S_IDLE;
      endcase
    end
  end

  // Byte capture, word assembly, write issue and status flags. The write is
  // registered, so it lands one cycle after the last byte of a word and
  // overlaps reception of the next word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_buf    <= '0;
      len_lo      <= '0;
      hdr_cnt     <= '0;
      byte_cnt    <= '0;
      data_buf    <= '0;
      chk_xor     <= '0;
      words_left  <= '0;
      word_ptr    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wen_o   <= '0;
      core_run_o  <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      mem_wen_o <= '0;
      if (acc) begin
        // Header byte counter restarts on every state change.
        if (state_nxt != state) hdr_cnt <= '0;
        else                    hdr_cnt <= hdr_cnt + 2'd1;

        case (state)
          S_ADDR: addr_buf <= {byte_i, addr_buf[31:8]};
          S_LEN: begin
            if (hdr_cnt == 2'd0) begin
              len_lo <= byte_i;
            end else begin
              word_ptr   <= start_word;
              words_left <= len_full;
              byte_cnt   <= '0;
              chk_xor    <= '0;
            end
          end
          S_DATA: begin
            chk_xor  <= chk_xor ^ byte_i;
            byte_cnt <= byte_cnt + BC_W'(1);
            if (byte_cnt == LAST_BC) begin
              mem_wen_o   <= '1;
              mem_addr_o  <= word_ptr;
              mem_wdata_o <= {byte_i, data_buf};
              word_ptr    <= word_ptr + ADDR_WIDTH'(1);
              words_left  <= words_left - 16'd1;
            end else begin
              data_buf <= {byte_i, data_buf[DATA_WIDTH-9:8]};
            end
          end
          default: ;
        endcase

        if (state_nxt != state) begin
          case (state_nxt)
            S_ADDR: begin
              done_o     <= 1'b0;
              err_o      <= 1'b0;
              core_run_o <= 1'b0;
            end
            S_DONE: begin
              done_o     <= 1'b1;
              core_run_o <= 1'b1;
            end
            S_ERR: begin
              err_o      <= 1'b1;
              core_run_o <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wen_o;
  logic        core_run_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  imem_loader #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .DATA_BYTES(4), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wen_o(mem_wen_o),
    .core_run_o(core_run_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          neg_cnt = 0;
  wr_t         sb[$];
  wr_t         ew[$];
  logic [7:0]  fb[$];
  wr_t         mon_w;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic busy,
                             input logic done, input logic err,
                             input logic run);
    check({tag, "_busy"}, {31'd0, busy_o}, {31'd0, busy});
    check({tag, "_done"}, {31'd0, done_o}, {31'd0, done});
    check({tag, "_err"},  {31'd0, err_o},  {31'd0, err});
    check({tag, "_run"},  {31'd0, core_run_o}, {31'd0, run});
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expected
  // write, including the cycle it was due in.
  always @(negedge clk) begin
    neg_cnt++;
    if (mem_wen_o !== 4'h0) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_unexpected: got wen=0x%0h addr=0x%0h data=0x%0h, expected no write",
                 mem_wen_o, mem_addr_o, mem_wdata_o);
      end else begin
        mon_w = sb.pop_front();
        check("wr_wen",  {28'd0, mem_wen_o}, 32'hF);
        check("wr_addr", {22'd0, mem_addr_o}, {22'd0, mon_w.addr});
        check("wr_data", mem_wdata_o, mon_w.data);
        check("wr_cycle", neg_cnt, mon_w.cyc);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_i       = b;
    byte_valid_i = 1'b1;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    byte_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic exp_add(input logic [9:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.cyc  = 0;
    ew.push_back(w);
  endtask

  // Sends fb back-to-back. Data starts at index d0; when the 4th byte of a
  // word is accepted, the next pending expected write becomes due on the
  // following cycle.
  task automatic send_frame(input int d0);
    wr_t w;
    for (int i = 0; i < fb.size(); i++) begin
      send(fb[i]);
      if (i >= d0 && ((i - d0) % 4) == 3 && ew.size() > 0) begin
        w     = ew.pop_front();
        w.cyc = neg_cnt + 1;
        sb.push_back(w);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] kb;
    rst          = 1'b1;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;

    // Reset asserted mid-cycle.
    #13 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, byte_ready_o}, 32'd1);
    check("rst_wen",   {28'd0, mem_wen_o}, 32'd0);
    check("rst_addr",  {22'd0, mem_addr_o}, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Good load at byte address 0x100; checksum 0x13^0x93^0x10 = 0x90.
    fb = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
           8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    exp_add(10'h040, 32'h0000_0013);
    exp_add(10'h041, 32'h0010_0093);
    send_frame(7);
    idle();
    check_flags("good", 1'b0, 1'b1, 1'b0, 1'b1);
    check("hold_addr",  {22'd0, mem_addr_o}, 32'h41);
    check("hold_wdata", mem_wdata_o, 32'h0010_0093);

    // Same frame with a bad checksum: words still written, then ERR.
    fb = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
           8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    exp_add(10'h040, 32'h0000_0013);
    exp_add(10'h041, 32'h0010_0093);
    send_frame(7);
    idle();
    check_flags("badchk", 1'b0, 1'b0, 1'b1, 1'b0);

    // A following good frame recovers to DONE (start word 0x3FF, N=1 is the
    // last legal position). Checksum 01^02^03^04 = 04.
    fb = '{8'hA5, 8'hFC, 8'h0F, 8'h00, 8'h00, 8'h01, 8'h00,
           8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    exp_add(10'h3FF, 32'h0403_0201);
    send_frame(7);
    idle();
    check_flags("top", 1'b0, 1'b1, 1'b0, 1'b1);

    // Header errors: misaligned, high address bit, overrun. No writes.
    fb = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
    send_frame(99);
    idle();
    check_flags("misalign", 1'b0, 1'b0, 1'b1, 1'b0);

    fb = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h01, 8'h00};
    send_frame(99);
    idle();
    check_flags("highbit", 1'b0, 1'b0, 1'b1, 1'b0);

    fb = '{8'hA5, 8'hFC, 8'h0F, 8'h00, 8'h00, 8'h02, 8'h00};
    send_frame(99);
    idle();
    check_flags("overrun", 1'b0, 1'b0, 1'b1, 1'b0);

    // Garbage ignored in ERR, then an N=0 frame; flags drop right after SYNC.
    send(8'h11);
    send(8'h22);
    #1;
    check_flags("garbage", 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'hA5);
    #1;
    check_flags("sync", 1'b1, 1'b0, 1'b0, 1'b0);
    fb = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(99);
    idle();
    check_flags("n0", 1'b0, 1'b1, 1'b0, 1'b1);

    // Back-to-back 8-word frame at address 0, reset during word 5.
    fb = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00};
    for (int k = 0; k < 4; k++) begin
      kb = 8'(k);
      fb.push_back(8'h10 + kb);
      fb.push_back(8'h20 + kb);
      fb.push_back(8'h30 + kb);
      fb.push_back(8'h40 + kb);
      exp_add(10'(k), {8'h40 + kb, 8'h30 + kb, 8'h20 + kb, 8'h10 + kb});
    end
    fb.push_back(8'h14);
    fb.push_back(8'h24);
    send_frame(7);
    #2 rst = 1'b0;
    @(negedge clk);
    byte_valid_i = 1'b0;
    check("midrst_wen", {28'd0, mem_wen_o}, 32'd0);
    check_flags("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Remainder of the interrupted frame is discarded in IDLE.
    fb = '{8'h34, 8'h44};
    for (int k = 5; k < 8; k++) begin
      kb = 8'(k);
      fb.push_back(8'h10 + kb);
      fb.push_back(8'h20 + kb);
      fb.push_back(8'h30 + kb);
      fb.push_back(8'h40 + kb);
    end
    fb.push_back(8'h00);
    send_frame(99);
    idle();
    check_flags("after_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
